// File: rtl/count_display_driver_pkg.sv
// Shared types and constants for the count display driver: converter FSM states,
// packed 3-digit BCD type, segment lookup and the add-3 helper used by double-dabble.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } dd_state_e;

    typedef logic [11:0] bcd3_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] AN_OFF    = 3'b111;
    localparam logic [2:0] AN_ONES   = 3'b110;
    localparam logic [2:0] AN_TENS   = 3'b101;
    localparam logic [2:0] AN_HUNDS  = 3'b011;

    // Active-low {g,f,e,d,c,b,a}; codes 10..15 cannot occur and drive blank.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    function automatic bcd3_t dd_adjust(input bcd3_t s);
        bcd3_t r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Bus between the count source and the display driver: the value to show plus
// the BCD result, its strobe/busy flags and the multiplexed segment drive.
interface count_display_driver_if;
    logic [7:0]  count;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (output count, input bcd, input bcd_valid, input busy, input seg, input an);
    modport slave  (input count, output bcd, output bcd_valid, output busy, output seg, output an);
endinterface

// File: rtl/count_display_driver_bcd_double_dabble.sv
// Sequential binary-to-BCD converter: restarts whenever the input differs from
// the last converted value, one shift/add-3 step per clock, 10 cycles idle to idle.
module bcd_double_dabble
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] count_i,
    output bcd3_t      bcd_o,
    output logic       bcd_valid_o,
    output logic       busy_o
);

    dd_state_e   state_q, state_d;
    logic [7:0]  val_q, val_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  shreg_q, shreg_d;
    bcd3_t       scratch_q, scratch_d;
    logic [2:0]  iter_q, iter_d;
    bcd3_t       bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    bcd3_t       adj_s;
    logic        carry_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (count_i != last_q) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        val_d     = val_q;
        last_d    = last_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        busy_d    = (state_d != IDLE);
        carry_s   = 1'b0;
        adj_s     = dd_adjust(scratch_q);
        case (state_q)
            IDLE: begin
                if (count_i != last_q) begin
                    val_d     = count_i;
                    shreg_d   = count_i;
                    scratch_d = 12'h000;
                    iter_d    = 3'd0;
                end else begin
                    val_d     = val_q;
                end
            end
            SHIFT: begin
                // Hundreds never exceeds 2, so the bit shifted out of scratch is always zero.
                {carry_s, scratch_d, shreg_d} = {adj_s, shreg_q, 1'b0};
                iter_d = iter_q + 3'd1;
            end
            DONE: begin
                bcd_d   = scratch_q;
                last_d  = val_q;
                valid_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q     <= 8'd0;
            last_q    <= 8'd0;
            shreg_q   <= 8'd0;
            scratch_q <= 12'h000;
            iter_q    <= 3'd0;
            bcd_q     <= 12'h000;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            val_q     <= val_d;
            last_q    <= last_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bcd_o       = bcd_q;
    assign bcd_valid_o = valid_q;
    assign busy_o      = busy_q;

endmodule

// File: rtl/count_display_driver.sv
// Count display driver top: BCD converter plus 3-digit multiplexed 7-segment scan.
// Define COUNT_DISPLAY_BLANK_LZ_EN to blank leading zeros on the tens/hundreds digits.
module count_display_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    count_display_driver_if.slave bus
);

    localparam logic [SCAN_DIV_WIDTH-1:0] PRESC_ONE = {{(SCAN_DIV_WIDTH-1){1'b0}}, 1'b1};

    bcd3_t                    bcd_s;
    logic                     bcd_valid_s;
    logic                     busy_s;
    logic [SCAN_DIV_WIDTH-1:0] presc_q, presc_d;
    logic [1:0]               digit_q, digit_d;
    logic [6:0]               seg_q, seg_d;
    logic [2:0]               an_q, an_d;
    logic [3:0]               nib_s;
    logic                     blank_s;
    logic                     blank_hund_s;
    logic                     blank_tens_s;

    bcd_double_dabble u_dd (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_i     (bus.count),
        .bcd_o       (bcd_s),
        .bcd_valid_o (bcd_valid_s),
        .busy_o      (busy_s)
    );

`ifdef COUNT_DISPLAY_BLANK_LZ_EN
    assign blank_hund_s = (bcd_s[11:8] == 4'd0);
    assign blank_tens_s = (bcd_s[11:8] == 4'd0) && (bcd_s[7:4] == 4'd0);
`else
    assign blank_hund_s = 1'b0;
    assign blank_tens_s = 1'b0;
`endif

    // Free-running prescaler; the digit index steps on its wrap.
    always_comb begin
        presc_d = presc_q + PRESC_ONE;
        if (&presc_q) begin
            case (digit_q)
                2'd0:    digit_d = 2'd1;
                2'd1:    digit_d = 2'd2;
                default: digit_d = 2'd0;
            endcase
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit select, segment decode and blanking for the current scan slot.
    always_comb begin
        case (digit_q)
            2'd0: begin
                an_d    = AN_ONES;
                nib_s   = bcd_s[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                an_d    = AN_TENS;
                nib_s   = bcd_s[7:4];
                blank_s = blank_tens_s;
            end
            2'd2: begin
                an_d    = AN_HUNDS;
                nib_s   = bcd_s[11:8];
                blank_s = blank_hund_s;
            end
            default: begin
                an_d    = AN_OFF;
                nib_s   = 4'hF;
                blank_s = 1'b1;
            end
        endcase
        if (blank_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = SEG_LUT[nib_s];
        end
    end

    // Scan state and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.bcd       = bcd_s;
    assign bus.bcd_valid = bcd_valid_s;
    assign bus.busy      = busy_s;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver with a 4-clock scan slot: stimulus
// queues expected conversions, a negedge monitor checks strobes, BCD and the scan.
module tb_count_display_driver;

    typedef struct {
        int val;
        int due;
    } exp_t;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic clk;
    logic rst_n;
    int   cyc;
    int   kcyc;
    int   errors;
    int   checks;
    int   model_last;
    int   last_due;
    int   model_val;
    exp_t sb[$];

    count_display_driver_if bus ();

    count_display_driver #(.SCAN_DIV_WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute cycle count and edges since reset release.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) kcyc <= 0;
        else        kcyc <= kcyc + 1;
    end

    function automatic logic [11:0] bcd_of(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int slot);
        int   d;
        logic blank;
        d     = (slot == 0) ? v % 10 : (slot == 1) ? (v / 10) % 10 : v / 100;
        blank = 1'b0;
`ifdef COUNT_DISPLAY_BLANK_LZ_EN
        if (slot == 2 && v < 100) blank = 1'b1;
        if (slot == 1 && v < 10)  blank = 1'b1;
`endif
        return blank ? 7'h7F : SEG_TAB[d];
    endfunction

    function automatic logic [2:0] exp_an(input int slot);
        return (slot == 0) ? 3'b110 : (slot == 1) ? 3'b101 : 3'b011;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Drive a new count just after an edge and queue the conversion it must cause.
    task automatic set_count(input int v);
        int start;
        @(posedge clk);
        #1;
        bus.count = 8'(v);
        if (v != model_last) begin
            start = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
            sb.push_back('{v, start + 9});
            last_due   = start + 9;
            model_last = v;
        end
    endtask

    // Monitor: compares every DUT output against the reference model each cycle.
    initial begin
        exp_t e;
        int   slot;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_val = 0;
                check("rst_seg", 32'(bus.seg), 32'h7F);
                check("rst_an", 32'(bus.an), 32'b111);
                check("rst_bcd", 32'(bus.bcd), 32'h000);
                check("rst_valid", 32'(bus.bcd_valid), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
            end else begin
                if (kcyc == 0) begin
                    check("rel_seg", 32'(bus.seg), 32'h7F);
                    check("rel_an", 32'(bus.an), 32'b111);
                end else begin
                    slot = ((kcyc - 1) / 4) % 3;
                    check("scan_an", 32'(bus.an), 32'(exp_an(slot)));
                    check("scan_seg", 32'(bus.seg), 32'(exp_seg(model_val, slot)));
                end
                if (sb.size() > 0 && cyc == sb[0].due) begin
                    e = sb.pop_front();
                    check("conv_valid", 32'(bus.bcd_valid), 32'd1);
                    check("conv_bcd", 32'(bus.bcd), 32'(bcd_of(e.val)));
                    check("conv_busy_end", 32'(bus.busy), 32'd0);
                    model_val = e.val;
                end else begin
                    if (sb.size() > 0 && cyc == sb[0].due - 9)
                        check("conv_busy_start", 32'(bus.busy), 32'd1);
                    check("valid_idle", 32'(bus.bcd_valid), 32'd0);
                end
                check("bcd_hold", 32'(bus.bcd), 32'(bcd_of(model_val)));
            end
        end
    end

    initial begin
        int v;
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        kcyc       = 0;
        model_last = 0;
        last_due   = 0;
        model_val  = 0;
        rst_n      = 1'b0;
        bus.count  = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // count stays 0: no conversion, scan rotates over zeros
        repeat (50) @(posedge clk);

        set_count(255);
        repeat (15) @(posedge clk);
        set_count(9);
        repeat (20) @(posedge clk);

        // second change arrives while the first conversion runs
        set_count(100);
        repeat (2) @(posedge clk);
        set_count(200);
        while (cyc <= last_due + 2) @(posedge clk);

        // reset in the middle of a conversion, then restart with the same input
        set_count(173);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        model_last = 0;
        last_due   = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.push_back('{173, cyc + 10});
        last_due   = cyc + 10;
        model_last = 173;
        while (cyc <= last_due + 2) @(posedge clk);

        set_count(250);
        repeat (20) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            v = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) v = model_last;
            set_count(v);
            repeat ($urandom_range(12, 20)) @(posedge clk);
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 8-bit button-press counter. Converts `count` to 3-digit BCD with a sequential double-dabble engine.
- Time-multiplexes the three digits onto one active-low common-anode 7-segment bus for the board display.
- Also exports the BCD value and a one-cycle update strobe for debug/other consumers.

Parameters:
- SCAN_DIV_WIDTH, 16: width of the free-running scan prescaler. The digit advances every 2^SCAN_DIV_WIDTH clocks.

Ports:
- clk  input  1  system clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset, one clock domain
- count  input  8  binary value to display, synchronous to clk, may change any cycle
- bcd  output  12  latest converted value: [11:8] hundreds, [7:4] tens, [3:0] ones
- bcd_valid  output  1  one-cycle pulse when `bcd` takes a new value
- busy  output  1  high while a conversion is in progress (states SHIFT, DONE)
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low
- an  output  3  digit enables, active-low one-hot; an[0] = ones digit

Behaviour:
- Reset (async assert, sync release): state=IDLE, last_val=0, bcd=12'h000, bcd_valid=0, busy=0, prescaler=0, digit_idx=0, seg=7'h7F, an=3'b111.
- FSM IDLE:
  - if count != last_val: latch count into shift register, clear BCD scratch, iter=0, go SHIFT.
  - else stay in IDLE.
- FSM SHIFT, one iteration per clock:
  - for each scratch nibble, if >=5 add 3; then shift {scratch, shreg} left 1.
  - iter increments; after the 8th iteration go DONE.
- FSM DONE:
  - bcd <= scratch, last_val <= latched value, bcd_valid=1 for this cycle only, go IDLE.
- Latency: count change sampled at edge E0. Then 8 SHIFT edges, then DONE. bcd/bcd_valid are visible after edge E9, i.e. 10 cycles from sampling. Idle-to-idle is 10 cycles.
- count changing during SHIFT/DONE is ignored for the current conversion. On return to IDLE it is compared again, so the output always converges to the latest stable value. No value is lost if count holds at least 10 cycles.
- count=0 after reset: no conversion, no bcd_valid (last_val already 0).
- Conversion range 0..255. Hundreds nibble never exceeds 2. Scratch is 12 bits and no overflow is possible.
- Scan:
  - prescaler increments every clock and wraps at all-ones.
  - on the wrap cycle digit_idx advances 0->1->2->0; value 3 is unreachable.
- seg/an are registered from digit_idx and bcd each clock. First update is the edge after reset release: an=3'b110, seg = ones digit.
- an encoding: digit_idx 0 -> 3'b110, 1 -> 3'b101, 2 -> 3'b011.
- Digit encoding (active-low), 0..9: 40,79,24,30,19,12,02,78,00,10 hex. Nibble values 10..15 drive blank (7F); these are unreachable by construction.
- Reset mid-conversion: conversion is aborted and all state returns to reset values. No bcd_valid is emitted.

Optional Feature:
- Macro: COUNT_DISPLAY_BLANK_LZ_EN.
- Defined: leading zeros are blanked. Hundreds digit shows seg=7F when bcd[11:8]==0. Tens digit shows seg=7F when bcd[11:8]==0 and bcd[7:4]==0. Ones digit is always shown. `an` is unaffected.
- Undefined: all three digits always show their decoded value, including leading '0' (seg=40).

Decomposition:
- Package display_pkg:
  - typedef fsm state enum {IDLE, SHIFT, DONE}
  - typedef bcd3_t (12-bit packed)
  - localparam digit-to-segment lookup array (16 entries, blanks for 10..15)
  - localparams SEG_BLANK=7'h7F and AN_OFF=3'b111
- One sub-module: bcd_double_dabble. It contains the FSM, shift/add-3 datapath, bcd, bcd_valid and busy.
- The top level holds the prescaler, digit mux, segment decode and blanking.

Test Plan:
- Reset, hold count=0 for 50 cycles -> bcd=000, bcd_valid never high, busy=0. an cycles 110/101/011 with SCAN_DIV_WIDTH=2 (every 4 clocks).
- count 0->255 at E0 -> busy high from E1, bcd=12'h255 and bcd_valid high exactly one cycle after E9; then busy=0.
- count=9, scan digit 0 -> an=110, seg=7'h10. With blank macro, digits 1/2 seg=7F; without macro, seg=40.
- count=100, then 200 three cycles later -> bcd_valid for 12'h100, then second pulse with 12'h200 exactly 10 cycles after the first.
- Assert rst_n low during SHIFT with count=173 -> outputs return to reset values immediately. After release, conversion restarts and yields 12'h173.
- count=250 held -> bcd=12'h250. Check hundreds/tens/ones segments 24/12/40 on an 011/101/110 respectively.
